cmp_minmax_tracker: RTL and testbench
=====================================

# cmp_minmax_tracker

Streaming two-stage magnitude-compare tracker. Accepts a stream of WIDTH-bit samples over a valid/ready handshake and compares each sample against the running maximum and minimum of all earlier samples. It updates both extremes and reports per-sample gt/lt/eq flags plus a saturating sample count. It sits downstream of the 16-bit combinational magnitude comparator stage and provides its registered, sequential use: same greater/equal/less semantics, applied over time.

## Interface
- WIDTH, 16, sample and extreme register width
- CNT_W, 8, width of saturating sample counter
- clk  input  1  single clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- clear  input  1  synchronous flush; empties tracker and pipeline
- in_valid  input  1  sample present
- in_data  input  WIDTH  sample value
- in_ready  output  1  tracker can take a sample this cycle
- res_valid  output  1  result register holds a result
- res_ready  input  1  consumer takes result
- res_data  output  WIDTH  sample the result refers to
- res_gt  output  1  sample > max before this sample
- res_lt  output  1  sample < min before this sample
- res_eq  output  1  sample == max before this sample
- res_first  output  1  sample was the first since reset/clear
- max_q  output  WIDTH  running maximum
- min_q  output  WIDTH  running minimum
- cnt_q  output  CNT_W  samples absorbed, saturates at all-ones
- empty  output  1  no sample absorbed since reset/clear

## Operation
- Reset (rst_n low, async): s1_valid=0, res_valid=0, all res_* flags=0, res_data=0, max_q=0, min_q=0, cnt_q=0, empty=1.
- S1 stage: on in_valid && in_ready, s1_data<=in_data, s1_valid<=1.
- Advance condition adv = s1_valid && (!res_valid || res_ready).
- in_ready = !clear && (!s1_valid || adv).
- On adv, the result register loads:
  - res_data = s1_data.
  - Flags are computed against max_q/min_q before the update.
  - If empty: res_first=1 and gt=lt=eq=0. max_q=min_q=s1_data, empty<=0.
  - Otherwise, res_first=0 and the flags are evaluated. max_q<=s1_data if gt. min_q<=s1_data if lt.
  - cnt_q increments by one, but holds at 2^CNT_W-1.
- If res_valid && res_ready && !adv, then res_valid<=0.
- While res_valid && !res_ready, all res_* outputs are held stable and S1 holds.
- clear has priority over everything else. Next edge: s1_valid=0, res_valid=0, flags=0, max_q=min_q=0, cnt_q=0, empty=1. Samples offered during clear are not accepted, because in_ready=0.
- Equality follows the comparator convention: eq only when all WIDTH bits match. gt and lt are mutually exclusive.

## Timing
- Latency: a sample accepted at edge k appears with res_valid=1 after edge k+1, and max_q/min_q/cnt_q are updated at the same edge.
- Throughput: one sample per cycle when res_ready is held high.
- in_ready is combinational from res_ready, s1_valid, res_valid and clear.
- There are no other combinational input-to-output paths.
- Results are produced in order. Each result compares against all strictly earlier samples.
- If reset is asserted mid-transfer, the in-flight S1 sample and the held result are discarded.

## Configuration
- CMP_TRK_SIGNED_EN defined: in_data, max_q and min_q are treated as two's complement for gt/lt/eq and for the extreme updates.
- CMP_TRK_SIGNED_EN undefined: all comparisons are unsigned. This is the default.
- Only comparison semantics change. Widths, handshake, counter and reset values are identical in both builds.

## Test plan
- Reset, then 5, 9, 3, 9 with res_ready=1:
  - Results, in order: first=1; gt=1; lt=1; eq=1.
  - Final state: max_q=9, min_q=3, cnt_q=4.
- Backpressure: res_ready=0 after the first result, while offering 2 further samples.
  - in_ready drops after S1 fills.
  - The res_* outputs stay frozen.
  - After res_ready=1, results drain in order with no loss or duplication.
- Assert clear while both stages are full:
  - Next cycle: res_valid=0, empty=1, cnt_q=0.
  - The next sample 0x0042 yields res_first=1 and max_q=min_q=0x0042.
- With CNT_W=2, send 5 samples: cnt_q reads 1, 2, 3, 3, 3.
- Samples 0x7FFF then 0x8000:
  - Unsigned build: gt=1, max_q=0x8000.
  - CMP_TRK_SIGNED_EN build: lt=1, min_q=0x8000.
- Drop rst_n asynchronously mid-stream, then release: all outputs hit their reset values immediately, and the next sample is first=1.

Source files
------------

// File: rtl/cmp_minmax_tracker.sv
// cmp_minmax_tracker
//   Streaming two-stage magnitude-compare tracker. Each accepted sample is
//   compared against the running maximum and minimum of all earlier samples.
//   Per-sample gt/lt/eq/first flags are reported through a result register
//   with a valid/ready handshake. The extremes and a saturating sample count
//   are updated at the same edge that loads the result.
//
//   Build option: define CMP_TRK_SIGNED_EN to compare samples and extremes as
//   two's complement. By default all comparisons are unsigned.
//
// Ports
//   clk, rst_n                : clock, asynchronous active-low reset
//   clear                     : synchronous flush of pipeline and tracker state
//   in_valid/in_ready/in_data : sample input handshake
//   res_valid/res_ready       : result output handshake
//   res_data                  : sample that the result refers to
//   res_gt/res_lt/res_eq      : sample vs. max (gt, eq) and vs. min (lt), as
//                               they stood before this sample
//   res_first                 : first sample since reset/clear
//   max_q/min_q/cnt_q/empty   : tracker state
module cmp_minmax_tracker #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_gt,
  output logic             res_lt,
  output logic             res_eq,
  output logic             res_first,
  output logic [WIDTH-1:0] max_q,
  output logic [WIDTH-1:0] min_q,
  output logic [CNT_W-1:0] cnt_q,
  output logic             empty
);

  function automatic logic is_gt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef CMP_TRK_SIGNED_EN
    return $signed(a) > $signed(b);
`else
    return a > b;
`endif
  endfunction

  function automatic logic is_lt(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
`ifdef CMP_TRK_SIGNED_EN
    return $signed(a) < $signed(b);
`else
    return a < b;
`endif
  endfunction

  // Counter sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic             s1_vld_p1;
  logic [WIDTH-1:0] s1_data_p1;
  logic             adv;
  logic             gt_p1;
  logic             lt_p1;
  logic             eq_p1;

  assign adv      = s1_vld_p1 && (!res_valid || res_ready);
  assign in_ready = !clear && (!s1_vld_p1 || adv);

  assign gt_p1 = is_gt(s1_data_p1, max_q);
  assign lt_p1 = is_lt(s1_data_p1, min_q);
  assign eq_p1 = (s1_data_p1 == max_q);

  // ---- stage 1: input capture ----
  // Sample data carries no reset; its valid bit qualifies it.
  always_ff @(posedge clk) begin
    if (in_valid && in_ready) s1_data_p1 <= in_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_vld_p1 <= 1'b0;
    end else if (clear) begin
      s1_vld_p1 <= 1'b0;
    end else if (in_valid && in_ready) begin
      s1_vld_p1 <= 1'b1;
    end else if (adv) begin
      s1_vld_p1 <= 1'b0;
    end
  end

  // ---- stage 2: compare, result register and tracker update ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_gt    <= 1'b0;
      res_lt    <= 1'b0;
      res_eq    <= 1'b0;
      res_first <= 1'b0;
      max_q     <= '0;
      min_q     <= '0;
      cnt_q     <= '0;
      empty     <= 1'b1;
    end else if (clear) begin
      res_valid <= 1'b0;
      res_data  <= '0;
      res_gt    <= 1'b0;
      res_lt    <= 1'b0;
      res_eq    <= 1'b0;
      res_first <= 1'b0;
      max_q     <= '0;
      min_q     <= '0;
      cnt_q     <= '0;
      empty     <= 1'b1;
    end else if (adv) begin
      res_valid <= 1'b1;
      res_data  <= s1_data_p1;
      cnt_q     <= sat_inc(cnt_q);
      if (empty) begin
        // First sample seeds both extremes; there is nothing to compare to.
        res_first <= 1'b1;
        res_gt    <= 1'b0;
        res_lt    <= 1'b0;
        res_eq    <= 1'b0;
        max_q     <= s1_data_p1;
        min_q     <= s1_data_p1;
        empty     <= 1'b0;
      end else begin
        res_first <= 1'b0;
        res_gt    <= gt_p1;
        res_lt    <= lt_p1;
        res_eq    <= eq_p1;
        if (gt_p1) max_q <= s1_data_p1;
        if (lt_p1) min_q <= s1_data_p1;
      end
    end else if (res_valid && res_ready) begin
      res_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cmp_minmax_tracker.sv
module tb_cmp_minmax_tracker;

  localparam int WIDTH = 16;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             clear = 1'b0;
  logic             in_valid = 1'b0;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_ready;
  logic             res_valid;
  logic             res_ready = 1'b1;
  logic [WIDTH-1:0] res_data;
  logic             res_gt, res_lt, res_eq, res_first;
  logic [WIDTH-1:0] max_q, min_q;
  logic [CNT_W-1:0] cnt_q;
  logic             empty;

  cmp_minmax_tracker #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .clear(clear),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .res_gt(res_gt), .res_lt(res_lt), .res_eq(res_eq), .res_first(res_first),
    .max_q(max_q), .min_q(min_q), .cnt_q(cnt_q), .empty(empty)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             gt, lt, eq, first;
    logic [WIDTH-1:0] mx, mn;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  bit   rnd_bp = 1'b0;

  // Reference model state: plain integers, ordering by numeric value.
  int   m_max = 0, m_min = 0, m_cnt = 0;
  bit   m_empty = 1'b1;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  function automatic int key(input logic [WIDTH-1:0] d);
`ifdef CMP_TRK_SIGNED_EN
    return int'($signed(d));
`else
    return int'({16'd0, d});
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, want);
    end
  endtask

  // Accept side: every accepted sample gets its expected result pushed.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_max = 0; m_min = 0; m_cnt = 0; m_empty = 1'b1;
    end else if (clear) begin
      q.delete();
      m_max = 0; m_min = 0; m_cnt = 0; m_empty = 1'b1;
    end else if (in_valid && in_ready) begin
      exp_t e;
      int   k;
      k = key(in_data);
      e = '0;
      e.data = in_data;
      if (m_empty) begin
        e.first = 1'b1;
        m_max = k; m_min = k; m_empty = 1'b0;
      end else begin
        e.gt = (k > m_max);
        e.lt = (k < m_min);
        e.eq = (k == m_max);
        if (k > m_max) m_max = k;
        if (k < m_min) m_min = k;
      end
      m_cnt = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      e.mx  = WIDTH'(m_max);
      e.mn  = WIDTH'(m_min);
      e.cnt = CNT_W'(m_cnt);
      q.push_back(e);
    end
  end

  // Monitor: compares whatever result is presented; pops on handshake.
  always @(negedge clk) begin
    if (rst_n && res_valid) begin
      exp_t got;
      got = {res_data, res_gt, res_lt, res_eq, res_first, max_q, min_q, cnt_q};
      n_vec++;
      if (q.size() == 0) begin
        n_err++;
        $display("FAIL result: unexpected result data=0x%0h", res_data);
      end else begin
        if (got !== q[0]) begin
          n_err++;
          $display("FAIL result: got d=%h g/l/e/f=%b%b%b%b max=%h min=%h cnt=%0d expected d=%h g/l/e/f=%b%b%b%b max=%h min=%h cnt=%0d",
                   got.data, got.gt, got.lt, got.eq, got.first, got.mx, got.mn, got.cnt,
                   q[0].data, q[0].gt, q[0].lt, q[0].eq, q[0].first, q[0].mx, q[0].mn, q[0].cnt);
        end
        if (res_ready) void'(q.pop_front());
      end
    end
  end

  // Random backpressure, changed only just after the active edge.
  always @(posedge clk) begin
    #1;
    if (rnd_bp) res_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [WIDTH-1:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    forever begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
      n++;
      if (n > 200) begin
        n_vec++; n_err++;
        $display("FAIL send_timeout: in_ready stuck 0 expected 1");
        in_valid = 1'b0;
        return;
      end
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(posedge clk); #2;
    res_ready = 1'b1;
    while ((q.size() != 0 || res_valid) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_queue_empty", 32'(q.size()), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic do_clear();
    @(negedge clk); clear = 1'b1;
    @(posedge clk); #1; clear = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, "_flags"}, 32'({res_gt, res_lt, res_eq, res_first}), 32'd0);
    chk({tag, "_res_data"}, 32'(res_data), 32'd0);
    chk({tag, "_max"}, 32'(max_q), 32'd0);
    chk({tag, "_min"}, 32'(min_q), 32'd0);
    chk({tag, "_cnt"}, 32'(cnt_q), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
  endtask

  logic [WIDTH-1:0] pool [4];

  initial begin
    pool[0] = 16'h0000; pool[1] = 16'hFFFF; pool[2] = 16'h7FFF; pool[3] = 16'h8000;

    #12;
    chk_reset_state("reset");
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic sequence
    res_ready = 1'b1;
    send(16'd5); send(16'd9); send(16'd3); send(16'd9);
    drain();
    chk("seq_max", 32'(max_q), 32'd9);
    chk("seq_min", 32'(min_q), 32'd3);
    chk("seq_cnt", 32'(cnt_q), 32'd4);

    // Backpressure: one result held, S1 full, third sample refused
    send(16'd20);
    res_ready = 1'b0;
    send(16'd1);
    in_valid = 1'b1; in_data = 16'd30;
    repeat (4) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
    end
    @(posedge clk); #1; res_ready = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    drain();
    chk("bp_max", 32'(max_q), 32'd30);
    chk("bp_min", 32'(min_q), 32'd1);

    // Clear with both stages full
    res_ready = 1'b0;
    send(16'h0100); send(16'h0200);
    do_clear();
    chk("clr_res_valid", 32'(res_valid), 32'd0);
    chk("clr_empty", 32'(empty), 32'd1);
    chk("clr_cnt", 32'(cnt_q), 32'd0);
    res_ready = 1'b1;
    send(16'h0042);
    drain();
    chk("clr_max", 32'(max_q), 32'h42);
    chk("clr_min", 32'(min_q), 32'h42);

    // Signedness boundary
    do_clear();
    send(16'h7FFF); send(16'h8000);
    drain();
`ifdef CMP_TRK_SIGNED_EN
    chk("sign_min", 32'(min_q), 32'h8000);
    chk("sign_max", 32'(max_q), 32'h7FFF);
`else
    chk("sign_max", 32'(max_q), 32'h8000);
    chk("sign_min", 32'(min_q), 32'h7FFF);
`endif

    // Random stream with random backpressure; counter saturates
    do_clear();
    rnd_bp = 1'b1;
    for (int i = 0; i < 80; i++) begin
      logic [WIDTH-1:0] d;
      d = ($urandom_range(0, 3) == 0) ? pool[$urandom_range(0, 3)] : WIDTH'($urandom);
      send(d);
      if ($urandom_range(0, 4) == 0) begin
        @(posedge clk); #1;
      end
    end
    @(posedge clk); #1;
    rnd_bp = 1'b0;
    drain();
    chk("rnd_cnt_sat", 32'(cnt_q), 32'(CNT_MAX));

    // Asynchronous reset mid-stream
    res_ready = 1'b0;
    send(16'h0011); send(16'h0022);
    in_valid = 1'b1; in_data = 16'h0033;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk_reset_state("areset");
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    res_ready = 1'b1;
    send(16'h1234);
    drain();
    chk("areset_max", 32'(max_q), 32'h1234);
    chk("areset_cnt", 32'(cnt_q), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
